grid_int_ctrl: RTL and testbench
================================

// Module: grid_int_ctrl
// PURPOSE
//  Interrupt controller between the touch/input processing unit and the 5-stage proc core.
//  Queues selected grid-cell events in a small FIFO and delivers them one at a time:
//   - one-cycle ipu_int pulse per event (proc flushes its front end on it);
//   - waits for int_ack, then enforces a quiet gap before the next event.
//  Drives the grid_coord value that the core's read-coord instruction samples.
// PARAMETERS
//  DEPTH      4    event FIFO entries (power of 2, >=2)
//  COORD_W    4    grid coordinate width
//  CELLS      9    valid coords are 0..CELLS-1; others rejected
//  GAP_CYC    16   idle cycles after int_ack before next ipu_int (>=1)
//  TIMEOUT    255  cycles in WAIT_ACK before retry (only with GRID_INT_TIMEOUT_EN)
// PORTS
//  clk         in   1        system clock
//  rst_n       in   1        asynchronous reset, active-low
//  evt_valid   in   1        one-cycle strobe: new cell selected; no backpressure
//  evt_coord   in   COORD_W  cell index, qualified by evt_valid
//  ipu_int     out  1        interrupt pulse to proc, exactly 1 cycle per delivery
//  int_ack     in   1        proc acknowledges the interrupt (1-cycle pulse)
//  grid_coord  out  COORD_W  coordinate of current/last delivered event, held stable
//  pending     out  log2(DEPTH)+1  FIFO occupancy
//  ovf         out  1        sticky: event dropped because FIFO full
//  bad_coord   out  1        sticky: event dropped because evt_coord >= CELLS
//  clr_err     in   1        synchronous clear of ovf and bad_coord
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0, FIFO empty, FSM=IDLE, counters 0.
//  Push: evt_valid & coord<CELLS & !full -> write at tail; visible in pending next cycle.
//   coord>=CELLS -> dropped, bad_coord<=1. Full -> dropped, ovf<=1. FIFO contents never altered.
//   clr_err and a new error in the same cycle: error wins (flag stays 1).
//  FSM:
//   IDLE   : !empty -> RAISE.
//   RAISE  : ipu_int=1 this cycle only; grid_coord<=head at entry; -> WAIT_ACK.
//   WAIT_ACK: int_ack -> pop head, gap counter<=GAP_CYC-1, -> GAP.
//   GAP    : counter down to 0, then -> IDLE (earliest next ipu_int = GAP_CYC+1 cycles after ack).
//  int_ack outside WAIT_ACK: ignored, no state change.
//  Latency: event into empty idle FIFO -> ipu_int exactly 2 cycles after the evt_valid cycle.
//  grid_coord: updates only on RAISE entry, otherwise holds (also through GAP and IDLE).
//  Simultaneous push and pop (ack while event arrives): both happen; pending unchanged.
//   Full FIFO + pop in the same cycle: push accepted, no ovf.
//  Pointers wrap modulo DEPTH; pending counts 0..DEPTH.
//  Mid-operation reset: queue discarded, no ack expected, ipu_int low immediately.
// CONFIGURATION
//  GRID_INT_TIMEOUT_EN defined: WAIT_ACK counts cycles; after TIMEOUT cycles without
//   int_ack -> back to RAISE: re-pulse ipu_int with the same head entry, no pop.
//   Counter restarts on every RAISE.
//  Undefined: WAIT_ACK waits forever; no timeout counter logic present.
// STRUCTURE
//  Package grid_int_pkg: FSM state encoding (IDLE, RAISE, WAIT_ACK, GAP) and the
//   CELLS default constant shared with the core's coord decode.
//  Sub-module grid_evt_fifo: DEPTH x COORD_W synchronous FIFO.
//   Ports push/pop/head/full/empty/count, same clk and rst_n.
//  FSM, gap/timeout counters and error flags stay in grid_int_ctrl.
// TESTING
//  1. Reset, evt_coord=5 strobe -> ipu_int 1 cycle, 2 cycles later; grid_coord=5;
//     ack -> pending=0; grid_coord stays 5.
//  2. Coords 1,2,3 back-to-back, ack each 3 cycles after its ipu_int -> 3 pulses in order 1,2,3;
//     each pulse >= GAP_CYC+1 cycles after previous ack.
//  3. Five events with no ack (DEPTH=4) -> pending=4 after 4 accepted; 5th sets ovf=1.
//     clr_err -> ovf=0.
//  4. evt_coord=9 or 15 -> not queued, bad_coord=1, no ipu_int.
//  5. FIFO full, event arrives in the same cycle as int_ack -> accepted, ovf stays 0, pending=4.
//  6. rst_n low during WAIT_ACK -> ipu_int=0, pending=0, grid_coord=0 asynchronously.
//     With GRID_INT_TIMEOUT_EN, no ack for TIMEOUT cycles -> ipu_int re-pulses with the same coord.

Source files
------------

// File: rtl/grid_int_pkg.sv
// Shared definitions for the grid interrupt controller: FSM encoding and default sizing.
package grid_int_pkg;

    // Number of valid grid cells; the core's coord decode uses the same constant.
    localparam int unsigned GRID_CELLS   = 9;
    localparam int unsigned GRID_DEPTH   = 4;
    localparam int unsigned GRID_COORD_W = 4;
    localparam int unsigned GRID_GAP_CYC = 16;
    localparam int unsigned GRID_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAISE    = 2'd1,
        WAIT_ACK = 2'd2,
        GAP      = 2'd3
    } grid_state_t;

endpackage

// File: rtl/grid_int_ctrl_if.sv
// Event/interrupt bus between the input processing unit, the proc core and grid_int_ctrl.
interface grid_int_ctrl_if #(
    parameter int unsigned DEPTH   = grid_int_pkg::GRID_DEPTH,
    parameter int unsigned COORD_W = grid_int_pkg::GRID_COORD_W
) ();
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               evt_valid;
    logic [COORD_W-1:0] evt_coord;
    logic               ipu_int;
    logic               int_ack;
    logic [COORD_W-1:0] grid_coord;
    logic [CNT_W-1:0]   pending;
    logic               ovf;
    logic               bad_coord;
    logic               clr_err;

    // Event source / interrupt consumer side
    modport master (
        output evt_valid, evt_coord, int_ack, clr_err,
        input  ipu_int, grid_coord, pending, ovf, bad_coord
    );

    // Controller side
    modport slave (
        input  evt_valid, evt_coord, int_ack, clr_err,
        output ipu_int, grid_coord, pending, ovf, bad_coord
    );
endinterface

// File: rtl/grid_evt_fifo.sv
// DEPTH x W synchronous event FIFO; push while full is accepted only alongside a pop.
module grid_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign head  = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of 2)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    // Storage write; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/grid_int_ctrl.sv
// Grid-cell interrupt controller: queues input events and delivers them to the proc core
// one at a time with a one-cycle ipu_int pulse, ack handshake and quiet gap.
// Optional build macro GRID_INT_TIMEOUT_EN: re-raise the same event if no ack arrives
// within TIMEOUT cycles.
module grid_int_ctrl
    import grid_int_pkg::*;
#(
    parameter int unsigned DEPTH   = GRID_DEPTH,
    parameter int unsigned COORD_W = GRID_COORD_W,
    parameter int unsigned CELLS   = GRID_CELLS,
    parameter int unsigned GAP_CYC = GRID_GAP_CYC
`ifdef GRID_INT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = GRID_TIMEOUT
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    grid_int_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    grid_state_t        state;
    grid_state_t        state_d;
    logic [GAP_W-1:0]   gap_cnt;
    logic               pop_c;
    logic               coord_ok_c;
    logic               push_c;
    logic [COORD_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               ipu_int_q;
    logic [COORD_W-1:0] grid_coord_q;
    logic               ovf_q;
    logic               bad_coord_q;

`ifdef GRID_INT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    assign coord_ok_c = (32'(bus.evt_coord) < CELLS);
    assign push_c     = bus.evt_valid & coord_ok_c;

    grid_evt_fifo #(
        .DEPTH (DEPTH),
        .W     (COORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .pop   (pop_c),
        .din   (bus.evt_coord),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state and pop decode
    always_comb begin
        state_d = state;
        pop_c   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_d = RAISE;
            end
            RAISE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.int_ack) begin
                    pop_c   = 1'b1;
                    state_d = GAP;
                end
`ifdef GRID_INT_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    state_d = RAISE;
                end
`endif
            end
            GAP: begin
                if (gap_cnt == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Quiet-gap counter, loaded on ack and run down in GAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (state == WAIT_ACK && bus.int_ack) begin
            gap_cnt <= GAP_W'(GAP_CYC - 1);
        end else if (state == GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

`ifdef GRID_INT_TIMEOUT_EN
    // Ack timeout counter: counts WAIT_ACK cycles, cleared elsewhere so each RAISE restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 tmo_cnt <= '0;
        else if (state == WAIT_ACK) tmo_cnt <= tmo_cnt + TMO_W'(1);
        else                        tmo_cnt <= '0;
    end
`endif

    // Interrupt pulse and coordinate latch, both taken on RAISE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ipu_int_q    <= 1'b0;
            grid_coord_q <= '0;
        end else begin
            ipu_int_q <= (state_d == RAISE);
            if (state_d == RAISE) grid_coord_q <= fifo_head;
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q       <= 1'b0;
            bad_coord_q <= 1'b0;
        end else begin
            ovf_q       <= (push_c & fifo_full & ~pop_c) | (ovf_q & ~bus.clr_err);
            bad_coord_q <= (bus.evt_valid & ~coord_ok_c) | (bad_coord_q & ~bus.clr_err);
        end
    end

    assign bus.ipu_int    = ipu_int_q;
    assign bus.grid_coord = grid_coord_q;
    assign bus.pending    = fifo_count;
    assign bus.ovf        = ovf_q;
    assign bus.bad_coord  = bad_coord_q;

endmodule

// File: tb/tb_grid_int_ctrl.sv
// Directed self-checking bench for grid_int_ctrl (default parameters).
module tb_grid_int_ctrl;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned COORD_W = 4;
    localparam int unsigned GAP_CYC = 16;
`ifdef GRID_INT_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 255;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_err    = 0;
    logic seen;
    int   t;
    int   ack_cyc;

    grid_int_ctrl_if #(.DEPTH(DEPTH), .COORD_W(COORD_W)) bus ();

    grid_int_ctrl #(
        .DEPTH   (DEPTH),
        .COORD_W (COORD_W),
        .CELLS   (9),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_evt(input logic [COORD_W-1:0] coord);
        bus.evt_valid = 1'b1;
        bus.evt_coord = coord;
        tick();
        bus.evt_valid = 1'b0;
    endtask

    // Bounded wait for an ipu_int pulse; returns whether it was seen and its cycle
    task automatic wait_int(input int budget, output logic found, output int at);
        found = 1'b0;
        at    = -1;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (bus.ipu_int === 1'b1) begin
                found = 1'b1;
                at    = cyc;
            end
        end
    endtask

    initial begin
        bus.evt_valid = 1'b0;
        bus.evt_coord = '0;
        bus.int_ack   = 1'b0;
        bus.clr_err   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: reset state, single event latency and hold of grid_coord
        check("rst_ipu_int",    32'(bus.ipu_int),    32'd0);
        check("rst_pending",    32'(bus.pending),    32'd0);
        check("rst_grid_coord", 32'(bus.grid_coord), 32'd0);
        check("rst_ovf",        32'(bus.ovf),        32'd0);
        check("rst_bad_coord",  32'(bus.bad_coord),  32'd0);
        push_evt(4'd5);
        check("t1_pending_1",   32'(bus.pending),    32'd1);
        check("t1_no_int_yet",  32'(bus.ipu_int),    32'd0);
        tick();
        check("t1_int_pulse",   32'(bus.ipu_int),    32'd1);
        check("t1_coord_5",     32'(bus.grid_coord), 32'd5);
        tick();
        check("t1_pulse_1cyc",  32'(bus.ipu_int),    32'd0);
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        ack_cyc = cyc;
        check("t1_pending_0",   32'(bus.pending),    32'd0);
        check("t1_coord_hold",  32'(bus.grid_coord), 32'd5);

        // 2: three queued events delivered in order, each GAP_CYC+1 after previous ack
        push_evt(4'd1);
        push_evt(4'd2);
        push_evt(4'd3);
        check("t2_pending_3",   32'(bus.pending),    32'd3);
        for (int k = 1; k <= 3; k++) begin
            wait_int(40, seen, t);
            check($sformatf("t2_pulse_%0d", k),     32'(seen),           32'd1);
            check($sformatf("t2_coord_%0d", k),     32'(bus.grid_coord), 32'(k));
            check($sformatf("t2_gap_%0d", k),       32'(t - ack_cyc),    32'(GAP_CYC + 1));
            tick();
            check($sformatf("t2_1cyc_%0d", k),      32'(bus.ipu_int),    32'd0);
            tick();
            bus.int_ack = 1'b1;
            tick();
            bus.int_ack = 1'b0;
            ack_cyc = cyc;
            check($sformatf("t2_pending_%0d", k),   32'(bus.pending),    32'(3 - k));
        end

        // 4: out-of-range coords are dropped and flagged, no interrupt
        check("t4_bad_pre",     32'(bus.bad_coord),  32'd0);
        push_evt(4'd9);
        check("t4_bad_9",       32'(bus.bad_coord),  32'd1);
        check("t4_pending_9",   32'(bus.pending),    32'd0);
        push_evt(4'd15);
        check("t4_bad_15",      32'(bus.bad_coord),  32'd1);
        check("t4_pending_15",  32'(bus.pending),    32'd0);
        wait_int(30, seen, t);
        check("t4_no_int",      32'(seen),           32'd0);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("t4_bad_clr",     32'(bus.bad_coord),  32'd0);

        // 3: fill without ack, overflow, clear-vs-error priority, clear
        push_evt(4'd4);
        push_evt(4'd1);
        push_evt(4'd2);
        push_evt(4'd3);
        check("t3_pending_4",   32'(bus.pending),    32'd4);
        check("t3_ovf_0",       32'(bus.ovf),        32'd0);
        check("t3_head_coord",  32'(bus.grid_coord), 32'd4);
        push_evt(4'd5);
        check("t3_ovf_1",       32'(bus.ovf),        32'd1);
        check("t3_pending_hold", 32'(bus.pending),   32'd4);
        bus.clr_err = 1'b1;
        push_evt(4'd7);
        bus.clr_err = 1'b0;
        check("t3_err_wins",    32'(bus.ovf),        32'd1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("t3_ovf_clr",     32'(bus.ovf),        32'd0);
        check("t3_pending_4b",  32'(bus.pending),    32'd4);

        // 5: full FIFO, event and ack in the same cycle
        bus.int_ack = 1'b1;
        push_evt(4'd8);
        bus.int_ack = 1'b0;
        ack_cyc = cyc;
        check("t5_pending_4",   32'(bus.pending),    32'd4);
        check("t5_no_ovf",      32'(bus.ovf),        32'd0);

        // 6: next delivery is coord 1, then asynchronous reset during the pulse
        wait_int(40, seen, t);
        check("t6_pulse",       32'(seen),           32'd1);
        check("t6_coord_1",     32'(bus.grid_coord), 32'd1);
        check("t6_gap",         32'(t - ack_cyc),    32'(GAP_CYC + 1));
        rst_n = 1'b0;
        #1;
        check("t6_rst_ipu",     32'(bus.ipu_int),    32'd0);
        check("t6_rst_pending", 32'(bus.pending),    32'd0);
        check("t6_rst_coord",   32'(bus.grid_coord), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        check("t6_post_pending", 32'(bus.pending),   32'd0);
        wait_int(25, seen, t);
        check("t6_queue_gone",  32'(seen),           32'd0);

`ifdef GRID_INT_TIMEOUT_EN
        // Timeout: no ack re-raises the same head entry without popping it
        push_evt(4'd6);
        wait_int(5, seen, t);
        check("tmo_first_pulse", 32'(seen),          32'd1);
        check("tmo_coord_a",    32'(bus.grid_coord), 32'd6);
        ack_cyc = t;
        wait_int(TIMEOUT + 10, seen, t);
        check("tmo_repulse",    32'(seen),           32'd1);
        check("tmo_interval",   32'(t - ack_cyc),    32'(TIMEOUT + 1));
        check("tmo_coord_b",    32'(bus.grid_coord), 32'd6);
        check("tmo_pending",    32'(bus.pending),    32'd1);
        tick();
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        check("tmo_popped",     32'(bus.pending),    32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
